// File: rtl/dmem_responder_pkg.sv
// Shared access-size codes and FSM state encodings for the data-memory responder.
package dmem_responder_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_BUSY = 2'b01;
   localparam state_t ST_RESP = 2'b10;

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte write enables and an asynchronous read port.
// Contents are deliberately not reset.
module dmem_array #(
   parameter int NUM_LOCS = 64,
   parameter int AW       = 6
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [NUM_LOCS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed access latency and byte/half/word sizing.
// Errors (misaligned, out of range, illegal size) report resp_err and never touch memory.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int NUM_LOCS = 64,
   parameter int LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_ls_type,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [1:0]  lat_type;
   logic        lat_uns;

   logic [1:0]  lane;
   logic [31:0] rword;
   logic [31:0] wword;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic [3:0]  be;
   logic [3:0]  we;
   logic        misaligned;
   logic        out_of_range;
   logic        access_err;
   logic        do_access;

   assign lane         = lat_addr[1:0];
   assign out_of_range = lat_addr >= 32'(4 * NUM_LOCS);
   assign access_err   = out_of_range | misaligned;
   assign do_access    = (state == ST_BUSY) && (cnt == 4'd0);
   assign req_ready    = (state == ST_IDLE) && !rst;

   always_comb begin
      misaligned = 1'b0;
      wword      = lat_wdata;
      be         = 4'b0000;
      shifted    = rword >> {lane, 3'b000};
      load_data  = 32'd0;
      case (lat_type)
         LS_BYTE: begin
            wword     = {4{lat_wdata[7:0]}};
            be        = 4'b0001 << lane;
            load_data = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
         end
         LS_HALF: begin
            misaligned = lane[0];
            wword      = {2{lat_wdata[15:0]}};
            be         = lane[1] ? 4'b1100 : 4'b0011;
            load_data  = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
         end
         LS_WORD: begin
            misaligned = |lane;
            be         = 4'b1111;
            load_data  = rword;
         end
         default: misaligned = 1'b1;
      endcase
   end

   // Write strobes are qualified by reset so an abandoned store can never land.
   assign we = (do_access && lat_write && !access_err && !rst) ? be : 4'b0000;

   dmem_array #(
      .NUM_LOCS(NUM_LOCS),
      .AW      (AW)
   ) u_array (
      .clk  (clk),
      .we   (we),
      .addr (lat_addr[2 +: AW]),
      .wdata(wword),
      .rdata(rword)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         lat_type   <= LS_BYTE;
         lat_uns    <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_type  <= req_ls_type;
                  lat_uns   <= req_unsigned;
                  cnt       <= 4'(LATENCY - 1);
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt == 4'd0) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= access_err;
                  resp_rdata <= (access_err || lat_write) ? 32'd0 : load_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'd0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array reference memory.
module tb_dmem_responder;

   localparam int NUM_LOCS = 64;
   localparam int LATENCY  = 2;
   localparam int NBYTES   = 4 * NUM_LOCS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [1:0]  req_ls_type = 2'b00;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  mem_m [NBYTES];
   logic [31:0] last_rdata;
   logic        last_err;

   always #5 clk = ~clk;

   dmem_responder #(.NUM_LOCS(NUM_LOCS), .LATENCY(LATENCY)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ls_type (req_ls_type),
      .req_unsigned(req_unsigned),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: memory as a flat byte array, sizes as byte counts.
   task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] t, input logic u,
                        output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] v;
      n  = 1 << t;
      er = (a >= 32'(NBYTES)) || (t == 2'd3) || (a % n != 0);
      rd = 32'd0;
      if (er) return;
      if (w) begin
         for (int i = 0; i < n; i++) mem_m[int'(a) + i] = d[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(mem_m[int'(a) + i]) << (8 * i));
         if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
         rd = v;
      end
   endtask

   // Called and returns at a falling edge; bubble=1 presents a request during the response handshake.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] t, input logic u, input int hold,
                         input logic bubble, input string tag);
      logic [31:0] exp_rd;
      logic        exp_er;
      logic [31:0] first;
      int          n;
      model(w, a, d, t, u, exp_rd, exp_er);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      req_ls_type = t; req_unsigned = u; resp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_write = $urandom; req_addr = $urandom_range(0, NBYTES - 1);
      req_wdata = $urandom; req_ls_type = $urandom; req_unsigned = $urandom;
      @(negedge clk);
      n = 0;
      while (!resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, 32'(n), 32'(LATENCY));
      chk({tag, ".rdata"}, resp_rdata, exp_rd);
      chk({tag, ".err"}, 32'(resp_err), 32'(exp_er));
      last_rdata = resp_rdata;
      last_err   = resp_err;
      first      = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, ".hold_vld"}, 32'(resp_valid), 32'd1);
         chk({tag, ".hold_dat"}, resp_rdata, first);
         chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      req_valid  = bubble;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, ".vld_drop"}, 32'(resp_valid), 32'd0);
      chk({tag, ".idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst.vld", 32'(resp_valid), 32'd0);
      chk("rst.rdata", resp_rdata, 32'd0);
      chk("rst.err", 32'(resp_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < NUM_LOCS; i++) do_req(1'b1, 32'(4 * i), $urandom, 2'd2, 1'b0, 0, 1'b0, "init");

      do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, "st_w10");
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_w10");
      chk("ld_w10.const", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, 1'b0, "ld_bs13");
      chk("ld_bs13.const", last_rdata, 32'hFFFFFFDE);
      do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, 1'b0, "ld_bu13");
      chk("ld_bu13.const", last_rdata, 32'h000000DE);
      do_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0, 1'b0, "ld_hs12");
      chk("ld_hs12.const", last_rdata, 32'hFFFFDEAD);
      do_req(1'b1, 32'h11, 32'h55, 2'd0, 1'b0, 0, 1'b0, "st_b11");
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_w10b");
      chk("ld_w10b.const", last_rdata, 32'hDEAD55EF);
      do_req(1'b1, 32'h12, 32'h12345678, 2'd2, 1'b0, 0, 1'b0, "st_mis");
      chk("st_mis.const", 32'(last_err), 32'd1);
      do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_oor");
      chk("ld_oor.const", 32'(last_err), 32'd1);
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, 1'b1, "hold");
      chk("hold.const", last_rdata, 32'hDEAD55EF);
      do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b0, "after_bubble");

      // Store abandoned by reset while the countdown is still running.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      req_ls_type = 2'd2; req_unsigned = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst.vld", 32'(resp_valid), 32'd0);
      chk("midrst.rdata", resp_rdata, 32'd0);
      chk("midrst.err", 32'(resp_err), 32'd0);
      chk("midrst.ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst.ready_after", 32'(req_ready), 32'd1);
      @(negedge clk);
      do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b0, "ld_w20");

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 15) == 0) ? $urandom_range(NBYTES, NBYTES + 64)
                                          : $urandom_range(0, NBYTES - 1);
         do_req($urandom, a, $urandom, 2'($urandom), $urandom,
                $urandom_range(0, 2), 1'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
